// File: rtl/sort_frame_collector.sv
// Groups the sorter's output stream into FRAME_LEN-sample frames held in a
// two-bank ping-pong store, replays each frame over valid/ready and reports stats.
module sort_frame_collector #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned FRAME_LEN = 8,
    localparam int unsigned IDX_W    = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              stats_valid,
    output logic [DATA_W-1:0] frame_min,
    output logic [DATA_W-1:0] frame_max,
    output logic [DATA_W-1:0] frame_median,
    output logic              order_err,
    output logic              overflow
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] MED_IDX  = IDX_W'(FRAME_LEN / 2 - 1);

    logic [DATA_W-1:0] r_mem [2][FRAME_LEN];
    logic [1:0]        r_full;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [IDX_W-1:0]  r_rd_idx;
    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_prev;
    logic              r_ord_flag;
    logic              r_stats_valid;
    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_med;
    logic              r_order_err;
    logic              r_overflow;

    logic w_wr_accept;
    logic w_wr_done;
    logic w_ord_bad;
    logic w_xfer;
    logic w_rd_done;
    logic w_cur_ready;
    logic w_next_ready;

    assign w_wr_accept = in_valid && !r_full[r_wr_bank];
    assign w_wr_done   = w_wr_accept && (r_wr_idx == LAST_IDX);
    assign w_ord_bad   = (r_wr_idx != '0) && (in_data < r_prev);
    assign w_xfer      = (r_state == S_STREAM) && out_ready;
    assign w_rd_done   = w_xfer && (r_rd_idx == LAST_IDX);

    // A frame completing this cycle counts as full so the reader starts one cycle after the last write.
    assign w_cur_ready  = r_full[r_rd_bank]  || (w_wr_done && (r_wr_bank == r_rd_bank));
    assign w_next_ready = r_full[~r_rd_bank] || (w_wr_done && (r_wr_bank != r_rd_bank));

    // NOTE: sample storage carries no reset; the full flags alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_bank][r_wr_idx] <= in_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full        <= '0;
            r_wr_bank     <= 1'b0;
            r_rd_bank     <= 1'b0;
            r_wr_idx      <= '0;
            r_rd_idx      <= '0;
            r_state       <= S_IDLE;
            r_prev        <= '0;
            r_ord_flag    <= 1'b0;
            r_stats_valid <= 1'b0;
            r_min         <= '0;
            r_max         <= '0;
            r_med         <= '0;
            r_order_err   <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_idx   <= w_wr_done ? '0 : r_wr_idx + 1'b1;
                r_prev     <= in_data;
                r_ord_flag <= (r_wr_idx == '0) ? 1'b0 : (r_ord_flag | w_ord_bad);
                if (w_wr_done) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= ~r_wr_bank;
                end
            end

            if (in_valid && r_full[r_wr_bank]) begin
                r_overflow <= 1'b1;
            end

            // Index 0 and the median slot are already stored; the maximum is the incoming sample.
            r_stats_valid <= w_wr_done;
            if (w_wr_done) begin
                r_min       <= r_mem[r_wr_bank][0];
                r_max       <= in_data;
                r_med       <= r_mem[r_wr_bank][MED_IDX];
                r_order_err <= r_ord_flag | w_ord_bad;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_cur_ready) begin
                        r_state  <= S_STREAM;
                        r_rd_idx <= '0;
                    end
                end
                default: begin
                    if (w_rd_done) begin
                        r_full[r_rd_bank] <= 1'b0;
                        r_rd_bank         <= ~r_rd_bank;
                        r_rd_idx          <= '0;
                        if (!w_next_ready) begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_xfer) begin
                        r_rd_idx <= r_rd_idx + 1'b1;
                    end
                end
            endcase
        end
    end

    assign out_valid    = (r_state == S_STREAM);
    assign out_data     = out_valid ? r_mem[r_rd_bank][r_rd_idx] : '0;
    assign out_idx      = r_rd_idx;
    assign out_last     = out_valid && (r_rd_idx == LAST_IDX);
    assign stats_valid  = r_stats_valid;
    assign frame_min    = r_min;
    assign frame_max    = r_max;
    assign frame_median = r_med;
    assign order_err    = r_order_err;
    assign overflow     = r_overflow;

endmodule

// File: doc/sort_frame_collector.md
Name: sort_frame_collector

Overview:
- Downstream consumer of the pipelined sorter.
- Takes the sorter's output stream (data plus data-valid) and groups every FRAME_LEN valid samples into one frame.
- Buffers frames in a two-bank ping-pong store.
- Replays each frame over a valid/ready interface and reports per-frame min, max and median, plus an ordering-check flag.

Parameters:
- DATA_W, 8: sample width in bits.
- FRAME_LEN, 8: samples per frame; must be ≥2.
- IDX_W, $clog2(FRAME_LEN): index width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  sorted sample from the sorter.
- in_valid  in  1  in_data is valid this cycle; no backpressure to the sorter.
- out_data  out  DATA_W  replayed sample.
- out_idx  out  IDX_W  position of out_data within its frame.
- out_last  out  1  out_data is the final sample of its frame.
- out_valid  out  1  out_data, out_idx and out_last are valid.
- out_ready  in  1  downstream accepts the current sample.
- stats_valid  out  1  one-cycle pulse; the stats outputs were updated.
- frame_min  out  DATA_W  sample at index 0 of the last completed frame.
- frame_max  out  DATA_W  sample at index FRAME_LEN-1 of the last completed frame.
- frame_median  out  DATA_W  sample at index FRAME_LEN/2-1 (lower median).
- order_err  out  1  last completed frame contained a decrease.
- overflow  out  1  sticky: a sample was dropped because both banks were full.

Behaviour:
- Reset:
  - All outputs are 0.
  - Both banks are empty; write bank = 0, read bank = 0.
  - Write index and read index are 0.
  - Read FSM is in IDLE.
  - Any partial frame is discarded.
  - rst takes priority over every other event in the same cycle.
- Write side:
  - Each cycle with in_valid=1 and the write bank not full: store in_data at [wr_bank][wr_idx] and increment wr_idx.
  - When wr_idx = FRAME_LEN-1 is written:
    - mark wr_bank full;
    - wr_idx wraps to 0;
    - wr_bank toggles.
  - in_valid=1 while the current write bank is full: drop the sample; overflow sets and stays set until rst.
- Order check:
  - Keep a per-frame running flag.
  - It sets when in_data < the previous accepted sample of the same frame (unsigned compare).
  - Index 0 is never compared.
  - The flag clears at frame start.
- Stats:
  - On the cycle after the last sample of a frame is written, stats_valid pulses high for exactly 1 cycle.
  - frame_min, frame_max, frame_median and order_err load in that same cycle.
  - They hold until the next frame completes.
  - Values are taken positionally, without re-sorting.
- Read FSM:
  - IDLE:
    - If rd_bank is full, go to STREAM the next cycle with out_valid=1 and rd_idx=0.
    - Latency is 1 cycle: last write at cycle T gives out_valid at T+1 when the reader is idle.
  - STREAM:
    - out_data = bank[rd_bank][rd_idx]; out_idx = rd_idx; out_last = (rd_idx = FRAME_LEN-1).
    - A transfer occurs when out_valid && out_ready.
    - On a non-last transfer, increment rd_idx.
    - On the last transfer: free rd_bank, toggle rd_bank, reset rd_idx to 0.
    - After the last transfer: if the new rd_bank is already full, stay in STREAM with no bubble; otherwise go to IDLE with out_valid=0.
  - Stability: while out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable. A valid is never withdrawn without a transfer.
- Simultaneous events:
  - A frame completing into bank X in the same cycle that bank X is freed cannot occur, because the writer targets the other bank.
  - If the writer completes bank A in the same cycle the reader frees bank B, both updates apply. The writer may then write B on the next cycle.
- Throughput: with out_ready held at 1, sustained in_valid=1 never overflows.

Test Plan:
1. Release rst, then drive in_valid=1 with 1,3,4,5,5,6,7,7 and hold out_ready=1.
   - stats_valid pulses once.
   - min=1, max=7, median=5, order_err=0.
   - out_valid rises 1 cycle after the 8th write; out_data streams 1,3,4,5,5,6,7,7 with out_idx 0..7.
   - out_last is high only with the second 7.
2. Drive 3,6,7,4,7,5,5,1.
   - order_err=1, min=3, max=1, median=4.
   - Next frame 0,1,2,3,4,5,6,7 gives order_err=0.
3. Hold out_ready=0 and send 3 full frames back to back.
   - The first 16 samples are stored.
   - Every sample of frame 3 is dropped; overflow=1 from the first dropped sample and stays set.
   - Raise out_ready: exactly frames 1 and 2 stream out, with no bubble between them.
4. Random out_ready at 50% over 20 frames of random sorted data.
   - Every frame is replayed in order with no loss or duplication.
   - out_data and out_idx are stable whenever out_valid && !out_ready.
5. Assert rst for 1 cycle after 5 samples of a frame, and separately in the middle of STREAM.
   - All outputs return to 0; overflow is cleared.
   - The next 8 samples form a fresh frame with correct stats.
6. Gap test: send in_valid in bursts of 3 with idle cycles between (values 10..17).
   - Frame completes after the 8th valid sample; stats min=10, max=17, median=13.
